// File: rtl/sys_bus_pkg.sv
// Shared types and helpers for the data-side bus controller.
package sys_bus_pkg;

   // Controller sequencing states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Kind of completion reported back to the CPU
   typedef logic [1:0] err_kind_t;

   localparam err_kind_t ERR_NONE    = 2'd0;
   localparam err_kind_t ERR_DECODE  = 2'd1;
   localparam err_kind_t ERR_TIMEOUT = 2'd2;

   // Width needed to hold a decoded slave index (at least one bit)
   function automatic int slv_idx_w(input int num_slv);
      return (num_slv > 1) ? $clog2(num_slv) : 1;
   endfunction

endpackage

// File: rtl/bus_wdt.sv
// Clearable wait-state counter; flags when an access has used its last allowed cycle.
module bus_wdt #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT);

   logic [CNT_W-1:0] cnt_reg;

   // Count ACCESS cycles without ready; clear whenever no access is in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (inc) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // The counter reads TIMEOUT-1 during the final permitted ACCESS cycle
   assign expire = (cnt_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sys_bus_ctrl.sv
// Registered CPU data-port bus controller: decodes the slave from the upper
// address bits, waits for the selected slave's ready, and returns a one-cycle
// completion with read data or an error (decode miss or timeout).
module sys_bus_ctrl
   import sys_bus_pkg::*;
#(
   parameter int NUM_SLV = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int SEL_LSB = 28,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      m_valid,
   input  logic [ADDR_W-1:0]         m_addr,
   input  logic [DATA_W-1:0]         m_wdata,
   input  logic                      m_wen,
   input  logic [DATA_W/8-1:0]       m_wstrb,
   output logic                      m_good,
   output logic [DATA_W-1:0]         m_rdata,
   output logic                      m_err,
   output logic [NUM_SLV-1:0]        s_sel,
   output logic [ADDR_W-1:0]         s_addr,
   output logic [DATA_W-1:0]         s_wdata,
   output logic                      s_wen,
   output logic [DATA_W/8-1:0]       s_wstrb,
   input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
   input  logic [NUM_SLV-1:0]        s_ready,
   output logic [ADDR_W-1:0]         err_addr,
   output logic [7:0]                err_cnt
);

   localparam int IDX_W     = ADDR_W - SEL_LSB;
   localparam int SLV_IDX_W = slv_idx_w(NUM_SLV);

   state_t                  state_reg;
   state_t                  state_next;
   logic [SLV_IDX_W-1:0]    idx_reg;
   logic [IDX_W-1:0]        idx_in;
   logic                    decode_ok;
   logic [NUM_SLV-1:0]      sel_vec;
   logic [DATA_W-1:0]       rd_masked [NUM_SLV];
   logic [DATA_W-1:0]       rd_mux;
   logic                    ready_hit;
   logic                    expire;
   logic                    accept;
   logic                    decode_err;
   logic                    timeout_err;
   logic [ADDR_W-1:0]       s_addr_reg;
   logic [DATA_W-1:0]       s_wdata_reg;
   logic                    s_wen_reg;
   logic [DATA_W/8-1:0]     s_wstrb_reg;
   logic [DATA_W-1:0]       m_rdata_reg;
   err_kind_t               err_kind_reg;
   logic [ADDR_W-1:0]       err_addr_reg;
   logic [7:0]              err_cnt_reg;
   logic [7:0]              err_cnt_next;

   // Slave index field of the incoming address and its range check
   assign idx_in    = m_addr[ADDR_W-1:SEL_LSB];
   assign decode_ok = (32'(idx_in) < NUM_SLV);

   assign accept      = (state_reg == IDLE) && m_valid;
   assign decode_err  = accept && !decode_ok;
   assign timeout_err = (state_reg == ACCESS) && !ready_hit && expire;

   // Per-slave select decode and masked read-data slices
   generate
      for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
         assign sel_vec[gi]   = (idx_reg == SLV_IDX_W'(gi));
         assign rd_masked[gi] = sel_vec[gi] ? s_rdata[gi*DATA_W +: DATA_W] : '0;
      end
   endgenerate

   // OR-combine the masked slices; at most one is non-zero
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         rd_mux = rd_mux | rd_masked[i];
      end
   end

   // Only the selected slave's ready can complete the access
   assign ready_hit = |(s_ready & sel_vec);

   bus_wdt #(
      .TIMEOUT (TIMEOUT)
   ) u_wdt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state_reg != ACCESS),
      .inc    ((state_reg == ACCESS) && !ready_hit),
      .expire (expire)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; ready takes priority over the timeout
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (m_valid) begin
               state_next = decode_ok ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            if (ready_hit || expire) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM-derived outputs
   always_comb begin
      m_good = (state_reg == RESP);
      m_err  = (err_kind_reg != ERR_NONE);
      s_sel  = (state_reg == ACCESS) ? sel_vec : '0;
   end

   // Saturating error counter increment
   always_comb begin
      err_cnt_next = (err_cnt_reg == 8'hFF) ? 8'hFF : err_cnt_reg + 8'd1;
   end

   // Request latch: captured once per accepted request and broadcast to slaves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_addr_reg  <= '0;
         s_wdata_reg <= '0;
         s_wen_reg   <= 1'b0;
         s_wstrb_reg <= '0;
         idx_reg     <= '0;
      end else if (accept) begin
         s_addr_reg  <= m_addr;
         s_wdata_reg <= m_wdata;
         s_wen_reg   <= m_wen;
         s_wstrb_reg <= m_wstrb;
         idx_reg     <= SLV_IDX_W'(idx_in);
      end
   end

   // Response and error bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rdata_reg  <= '0;
         err_kind_reg <= ERR_NONE;
         err_addr_reg <= '0;
         err_cnt_reg  <= '0;
      end else begin
         if (decode_err) begin
            m_rdata_reg  <= '0;
            err_kind_reg <= ERR_DECODE;
            err_addr_reg <= m_addr;
            err_cnt_reg  <= err_cnt_next;
         end else if (accept) begin
            err_kind_reg <= ERR_NONE;
         end else if ((state_reg == ACCESS) && ready_hit) begin
            m_rdata_reg  <= s_wen_reg ? '0 : rd_mux;
            err_kind_reg <= ERR_NONE;
         end else if (timeout_err) begin
            m_rdata_reg  <= '0;
            err_kind_reg <= ERR_TIMEOUT;
            err_addr_reg <= s_addr_reg;
            err_cnt_reg  <= err_cnt_next;
         end
      end
   end

   assign s_addr   = s_addr_reg;
   assign s_wdata  = s_wdata_reg;
   assign s_wen    = s_wen_reg;
   assign s_wstrb  = s_wstrb_reg;
   assign m_rdata  = m_rdata_reg;
   assign err_addr = err_addr_reg;
   assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Self-checking bench for sys_bus_ctrl with a transaction-level reference model.
module tb_sys_bus_ctrl;

   localparam int NUM_SLV = 4;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int SEL_LSB = 28;
   localparam int TIMEOUT = 64;
   localparam int NEVER   = 1000;

   logic                      clk;
   logic                      rst_n;
   logic                      m_valid;
   logic [ADDR_W-1:0]         m_addr;
   logic [DATA_W-1:0]         m_wdata;
   logic                      m_wen;
   logic [DATA_W/8-1:0]       m_wstrb;
   logic                      m_good;
   logic [DATA_W-1:0]         m_rdata;
   logic                      m_err;
   logic [NUM_SLV-1:0]        s_sel;
   logic [ADDR_W-1:0]         s_addr;
   logic [DATA_W-1:0]         s_wdata;
   logic                      s_wen;
   logic [DATA_W/8-1:0]       s_wstrb;
   logic [NUM_SLV*DATA_W-1:0] s_rdata;
   logic [NUM_SLV-1:0]        s_ready;
   logic [ADDR_W-1:0]         err_addr;
   logic [7:0]                err_cnt;

   int          checks = 0;
   int          errors = 0;
   int          model_err_cnt = 0;
   logic [31:0] model_err_addr = '0;
   time         last_good_t = 0;

   sys_bus_ctrl #(
      .NUM_SLV (NUM_SLV),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .SEL_LSB (SEL_LSB),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m_valid  (m_valid),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_wen    (m_wen),
      .m_wstrb  (m_wstrb),
      .m_good   (m_good),
      .m_rdata  (m_rdata),
      .m_err    (m_err),
      .s_sel    (s_sel),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_wen    (s_wen),
      .s_wstrb  (s_wstrb),
      .s_rdata  (s_rdata),
      .s_ready  (s_ready),
      .err_addr (err_addr),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One complete transaction against the reference model. 'waits' is the number
   // of ACCESS cycles before the slave raises ready (NEVER = slave stays silent).
   task automatic run_txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int waits, input logic [31:0] rval,
                          input string name);
      int          idx;
      int          acc_len;
      int          lat;
      int          c;
      int          sel_bad;
      int          bus_bad;
      int          wr_hits;
      bit          dec;
      bit          done;
      bit          exp_err;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_sel;
      logic [3:0]  onehot;

      idx     = int'(addr[31:28]);
      dec     = (idx >= NUM_SLV);
      onehot  = dec ? 4'b0000 : 4'(1 << idx);
      if (dec) begin
         acc_len = 0;
         lat     = 1;
         exp_err = 1'b1;
      end else if (waits + 1 <= TIMEOUT) begin
         acc_len = waits + 1;
         lat     = waits + 2;
         exp_err = 1'b0;
      end else begin
         acc_len = TIMEOUT;
         lat     = TIMEOUT + 1;
         exp_err = 1'b1;
      end
      exp_rdata = (exp_err || wen) ? 32'h0 : rval;
      if (exp_err) begin
         model_err_addr = addr;
         model_err_cnt  = (model_err_cnt >= 255) ? 255 : model_err_cnt + 1;
      end

      @(posedge clk);
      @(negedge clk);
      checks++;
      if (m_good !== 1'b0) begin
         $display("FAIL %s idle_good: got %b want 0", name, m_good);
         errors++;
      end

      m_valid = 1'b1;
      m_addr  = addr;
      m_wen   = wen;
      m_wdata = wdata;
      m_wstrb = wstrb;
      s_ready = '0;
      for (int i = 0; i < NUM_SLV; i++) s_rdata[i*DATA_W +: DATA_W] = $urandom;

      done    = 1'b0;
      c       = 0;
      sel_bad = 0;
      bus_bad = 0;
      wr_hits = 0;
      while (!done && c < lat + 20) begin
         @(posedge clk);
         c++;
         @(negedge clk);
         exp_sel = (c <= acc_len) ? onehot : 4'b0000;
         if (s_sel !== exp_sel) sel_bad++;
         if (c <= acc_len &&
             (s_addr !== addr || s_wen !== wen || s_wdata !== wdata || s_wstrb !== wstrb))
            bus_bad++;
         if (m_good === 1'b1) begin
            done        = 1'b1;
            last_good_t = $time;
            checks++;
            if (c != lat) begin
               $display("FAIL %s latency: got %0d want %0d", name, c, lat);
               errors++;
            end
            checks++;
            if (m_rdata !== exp_rdata) begin
               $display("FAIL %s rdata: got %h want %h", name, m_rdata, exp_rdata);
               errors++;
            end
            checks++;
            if (m_err !== exp_err) begin
               $display("FAIL %s err: got %b want %b", name, m_err, exp_err);
               errors++;
            end
            checks++;
            if (err_addr !== model_err_addr || err_cnt !== 8'(model_err_cnt)) begin
               $display("FAIL %s err_log: got addr %h cnt %0d want addr %h cnt %0d",
                        name, err_addr, err_cnt, model_err_addr, model_err_cnt);
               errors++;
            end
            m_valid = 1'b0;
            s_ready = '0;
         end else begin
            // Unselected slaves chatter with random data and ready
            for (int i = 0; i < NUM_SLV; i++) s_rdata[i*DATA_W +: DATA_W] = $urandom;
            s_ready = NUM_SLV'($urandom);
            if (!dec) begin
               s_rdata[idx*DATA_W +: DATA_W] = rval;
               s_ready[idx] = (c == waits + 1);
               if (s_sel[idx] && s_ready[idx] && s_wen) wr_hits++;
            end
         end
      end

      checks++;
      if (!done) begin
         $display("FAIL %s no_good: got none within %0d cycles want cycle %0d", name, c, lat);
         errors++;
         m_valid = 1'b0;
      end
      checks++;
      if (sel_bad != 0) begin
         $display("FAIL %s s_sel: got %0d bad cycles want 0", name, sel_bad);
         errors++;
      end
      checks++;
      if (bus_bad != 0) begin
         $display("FAIL %s s_bus: got %0d bad cycles want 0", name, bus_bad);
         errors++;
      end
      checks++;
      if (wr_hits != ((wen && !exp_err) ? 1 : 0)) begin
         $display("FAIL %s write_once: got %0d want %0d", name, wr_hits, (wen && !exp_err) ? 1 : 0);
         errors++;
      end
      $display("txn %-10s addr=%h wen=%b waits=%0d lat=%0d rdata=%h err=%b cnt=%0d",
               name, addr, wen, waits, c, m_rdata, m_err, err_cnt);
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if (m_good !== 1'b0 || m_rdata !== '0 || m_err !== 1'b0 || s_sel !== '0) begin
         $display("FAIL %s resp_outputs: got good %b rdata %h err %b sel %b want all 0",
                  name, m_good, m_rdata, m_err, s_sel);
         errors++;
      end
      checks++;
      if (s_addr !== '0 || s_wdata !== '0 || s_wen !== 1'b0 || s_wstrb !== '0) begin
         $display("FAIL %s bus_outputs: got addr %h wdata %h wen %b wstrb %b want all 0",
                  name, s_addr, s_wdata, s_wen, s_wstrb);
         errors++;
      end
      checks++;
      if (err_addr !== '0 || err_cnt !== 8'd0) begin
         $display("FAIL %s err_log: got addr %h cnt %0d want 0 0", name, err_addr, err_cnt);
         errors++;
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      m_valid = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_wen   = 1'b0;
      m_wstrb = '0;
      s_rdata = '0;
      s_ready = '0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);
      $display("txn reset      outputs at reset values");
   endtask

   task automatic test_read();
      run_txn(32'h1000_0010, 1'b0, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, "read_s1");
   endtask

   task automatic test_write_wait();
      run_txn(32'h0000_0040, 1'b1, 32'hCAFE_F00D, 4'b0011, 3, 32'h1234_5678, "write_s0");
   endtask

   task automatic test_decode();
      run_txn(32'h5000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, "decode");
   endtask

   task automatic test_timeout();
      run_txn(32'h2000_0100, 1'b0, 32'h0, 4'hF, NEVER, 32'hAAAA_5555, "timeout");
      run_txn(32'h2000_0104, 1'b0, 32'h0, 4'hF, TIMEOUT - 1, 32'h5555_AAAA, "last_ok");
   endtask

   task automatic test_back_to_back();
      time t1;
      run_txn(32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0BAD_CAFE, "b2b_a");
      t1 = last_good_t;
      run_txn(32'h1000_0004, 1'b1, 32'h8765_4321, 4'b1100, 0, 32'h1111_2222, "b2b_b");
      checks++;
      if (last_good_t - t1 != 30) begin
         $display("FAIL b2b spacing: got %0t want 30", last_good_t - t1);
         errors++;
      end
   endtask

   task automatic test_random();
      logic [31:0] addr;
      int          r;
      int          waits;
      for (int n = 0; n < 30; n++) begin
         addr = {4'($urandom_range(0, 5)), 28'($urandom)};
         r    = $urandom_range(0, 9);
         if (r < 7)       waits = $urandom_range(0, 4);
         else if (r == 7) waits = $urandom_range(TIMEOUT - 2, TIMEOUT - 1);
         else if (r == 8) waits = TIMEOUT;
         else             waits = NEVER;
         run_txn(addr, 1'($urandom), $urandom, 4'($urandom), waits, $urandom, "random");
      end
   endtask

   task automatic test_reset_mid_access();
      m_valid = 1'b1;
      m_addr  = 32'h2000_0200;
      m_wen   = 1'b1;
      m_wdata = 32'h0F0F_0F0F;
      m_wstrb = 4'hF;
      s_ready = '0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_sel !== 4'b0100) begin
         $display("FAIL rst_mid pre_sel: got %b want 0100", s_sel);
         errors++;
      end
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("rst_mid");
      m_valid        = 1'b0;
      model_err_cnt  = 0;
      model_err_addr = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (m_good !== 1'b0 || s_sel !== '0) begin
            $display("FAIL rst_mid after_release: got good %b sel %b want 0 0", m_good, s_sel);
            errors++;
         end
      end
      $display("txn rst_mid    in-flight access abandoned");
      run_txn(32'h1000_0020, 1'b0, 32'h0, 4'hF, 1, 32'h600D_600D, "recover");
   endtask

   task automatic test_err_saturation();
      for (int n = 0; n < 300; n++) begin
         run_txn({4'($urandom_range(4, 15)), 28'($urandom)}, 1'($urandom), $urandom,
                 4'($urandom), 0, 32'h0, "sat");
      end
      checks++;
      if (err_cnt !== 8'd255) begin
         $display("FAIL sat err_cnt: got %0d want 255", err_cnt);
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_wait();
      test_decode();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid_access();
      test_err_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
